video_sync_generator: RTL and testbench
=======================================

# video_sync_generator

Programmable raster timing generator for the video pipeline. It produces pixel/line counters, active/blank flags, frame-boundary strobes, a position-match flag, a per-second frame counter and polarity-selectable horizontal/vertical sync. It sits at the head of the synchronous video pipe, and downstream stages delay its outputs to align with pixel data.

## Interface
- HCW, 12, horizontal counter / horizontal config width
- VCW, 12, vertical counter / vertical config width
- F_CNT, 60, frames per second; f_cnt wraps at this value. FCW = $clog2(F_CNT), which is 6 for the default.

Reset and clock: reset rst, asynchronous, active-high; clock clk.

- clk  in  1  video clock
- rst  in  1  async reset, active-high
- clk_en  in  1  clock enable; all state advances only when 1
- en  in  1  counter enable
- h_match  in  HCW  horizontal compare value
- v_match  in  VCW  vertical compare value
- cfg_h_pol  in  1  hsync polarity: 0 = positive, 1 = negative
- cfg_h_sync, cfg_h_active, cfg_h_front, cfg_h_whole  in  HCW each  sync width, active width, front porch, total line length (pixels)
- cfg_v_pol  in  1  vsync polarity: 0 = positive, 1 = negative
- cfg_v_sync, cfg_v_active, cfg_v_front, cfg_v_whole  in  VCW each  same quantities, counted in lines
- h_cnt  out  HCW  pixel counter
- v_cnt  out  VCW  line counter
- cnt_match  out  1  counters equal match values
- active  out  1  visible area
- blank  out  1  inverse of active
- a_start  out  1  first active pixel of frame
- a_end  out  1  last active pixel of frame
- f_cnt  out  FCW  frame counter
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync

## Operation
- Line layout in h_cnt: active [0, HA), front porch [HA, HA+HF), sync [HA+HF, HA+HF+HS), back porch up to HW-1. Frame layout in v_cnt uses the same scheme in lines.
- Config constraint: A+F+S ≤ W for both axes. All sums use HCW/VCW bits.
- Counting happens when clk_en && en:
  - h_cnt increments each clock.
  - If h_cnt ≥ cfg_h_whole-1, h_cnt → 0 and the line ends. The ≥ comparison makes a live reduction of cfg_*_whole safe.
  - At line end, v_cnt increments; if v_cnt ≥ cfg_v_whole-1, v_cnt → 0 and the frame ends.
  - At frame end, f_cnt increments, wrapping F_CNT-1 → 0.
- When en=0 (with clk_en=1), h_cnt, v_cnt and f_cnt are synchronously cleared to 0. Restarting en begins at pixel (0,0).
- When clk_en=0, all registers hold.
- Decoded outputs are combinational functions of the registered counters and en, so they are aligned to h_cnt/v_cnt in the same cycle:
  - active = en && h_cnt<HA && v_cnt<VA; blank = !active.
  - a_start = en && h_cnt==0 && v_cnt==0.
  - a_end = en && h_cnt==HA-1 && v_cnt==VA-1.
  - cnt_match = en && h_cnt==h_match && v_cnt==v_match.
  - h_sync = cfg_h_pol XOR (en && HA+HF ≤ h_cnt < HA+HF+HS).
  - v_sync = cfg_v_pol XOR (en && VA+VF ≤ v_cnt < VA+VF+VS). Asserted for whole lines.
- With en=0 the syncs sit at their inactive level (equal to pol), and active, a_start, a_end and cnt_match are 0.

## Timing
- Reset values: h_cnt=0, v_cnt=0, f_cnt=0. During reset, decoded outputs follow the en rule above at position (0,0).
- Counter latency is one clock. Decode latency is zero relative to the counters.
- Line period is HW enabled clocks. Frame period is HW×VW enabled clocks.
- a_end is followed, VW×HW - (HA-1) - (VA-1)×HW enabled clocks later, by a_start.
- Simultaneous line end and frame end: h_cnt, v_cnt and f_cnt update in the same clock.
- Reset asserted mid-frame: immediate return to (0,0) and f_cnt=0.
- en deasserted mid-line: next enabled clock gives (0,0).
- Config or polarity change: takes effect on the next comparison. No glitch protection is required.

## Test plan
- Timing set HA=800, HF=40, HS=128, HW=1056; VA=600, VF=1, VS=4, VW=628; pol=0; en=1; clk_en=1. Expected responses:
  - h_sync=1 exactly for h_cnt 840..967.
  - v_sync=1 exactly for v_cnt 601..604.
  - active=1 for h<800 && v<600.
  - Frame period is 663168 clocks.
- Same timing with pol=1/1 → sync levels inverted. Toggle clk_en every other cycle → each period doubles and counters hold on disabled cycles.
- a_start=1 only at (0,0); a_end=1 only at (799,599).
- Set h_match=5, v_match=3 → cnt_match=1 exactly once per frame, at (5,3).
- Run 60 frames → f_cnt goes 0..59 then wraps to 0 at the end of frame 60.
- Drop en at (300,200) → next clock is (0,0) with active=0 and syncs = pol.
- Assert rst asynchronously mid-line → counters read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/video_sync_generator.sv
// Purpose: programmable raster timing generator (pixel/line/frame counters, decoded flags, syncs).
// Latency: counters advance one clock after an enabled edge; decoded outputs are zero-latency from the counters.
// Backpressure: none; clk_en stalls every register, en=0 synchronously parks the raster at (0,0).
//
// Ports:
//   clk, rst             video clock, asynchronous active-high reset
//   clk_en, en           global clock enable, counter enable
//   h_match, v_match     position compare values for cnt_match
//   cfg_h_* / cfg_v_*    polarity, sync width, active width, front porch, total (pixels / lines)
//   h_cnt, v_cnt, f_cnt  raster position and frame-within-second counter
//   cnt_match, active, blank, a_start, a_end, h_sync, v_sync   decoded raster flags
module video_sync_generator #(
    parameter int HCW   = 12,
    parameter int VCW   = 12,
    parameter int F_CNT = 60,
    localparam int FCW  = (F_CNT > 1) ? $clog2(F_CNT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           en,
    input  logic [HCW-1:0] h_match,
    input  logic [VCW-1:0] v_match,
    input  logic           cfg_h_pol,
    input  logic [HCW-1:0] cfg_h_sync,
    input  logic [HCW-1:0] cfg_h_active,
    input  logic [HCW-1:0] cfg_h_front,
    input  logic [HCW-1:0] cfg_h_whole,
    input  logic           cfg_v_pol,
    input  logic [VCW-1:0] cfg_v_sync,
    input  logic [VCW-1:0] cfg_v_active,
    input  logic [VCW-1:0] cfg_v_front,
    input  logic [VCW-1:0] cfg_v_whole,
    output logic [HCW-1:0] h_cnt,
    output logic [VCW-1:0] v_cnt,
    output logic           cnt_match,
    output logic           active,
    output logic           blank,
    output logic           a_start,
    output logic           a_end,
    output logic [FCW-1:0] f_cnt,
    output logic           h_sync,
    output logic           v_sync
);

    localparam logic [FCW-1:0] F_LAST = FCW'(F_CNT - 1);

    logic [HCW-1:0] h_last;
    logic [VCW-1:0] v_last;
    logic           line_end;
    logic           frame_end;

    // ">=" rather than "==" so that shrinking cfg_*_whole below the current
    // position still wraps on the next clock instead of running to the top.
    assign h_last    = cfg_h_whole - HCW'(1);
    assign v_last    = cfg_v_whole - VCW'(1);
    assign line_end  = (h_cnt >= h_last);
    assign frame_end = line_end && (v_cnt >= v_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            f_cnt <= '0;
        end else if (clk_en) begin
            if (!en) begin
                h_cnt <= '0;
                v_cnt <= '0;
                f_cnt <= '0;
            end else begin
                if (line_end) begin
                    h_cnt <= '0;
                    if (frame_end) begin
                        v_cnt <= '0;
                        f_cnt <= (f_cnt >= F_LAST) ? '0 : f_cnt + FCW'(1);
                    end else begin
                        v_cnt <= v_cnt + VCW'(1);
                    end
                end else begin
                    h_cnt <= h_cnt + HCW'(1);
                end
            end
        end
    end

    // Sync window boundaries; sums wrap at the axis width by construction.
    logic [HCW-1:0] h_sync_beg;
    logic [HCW-1:0] h_sync_end;
    logic [VCW-1:0] v_sync_beg;
    logic [VCW-1:0] v_sync_end;
    logic           h_in_sync;
    logic           v_in_sync;
    logic           h_in_act;
    logic           v_in_act;

    assign h_sync_beg = cfg_h_active + cfg_h_front;
    assign h_sync_end = h_sync_beg + cfg_h_sync;
    assign v_sync_beg = cfg_v_active + cfg_v_front;
    assign v_sync_end = v_sync_beg + cfg_v_sync;

    assign h_in_sync  = (h_cnt >= h_sync_beg) && (h_cnt < h_sync_end);
    assign v_in_sync  = (v_cnt >= v_sync_beg) && (v_cnt < v_sync_end);
    assign h_in_act   = (h_cnt < cfg_h_active);
    assign v_in_act   = (v_cnt < cfg_v_active);

    // Decoded flags are gated by en so a parked raster shows nothing active
    // and both syncs rest at their inactive (pol) level.
    assign active    = en && h_in_act && v_in_act;
    assign blank     = !active;
    assign a_start   = en && (h_cnt == '0) && (v_cnt == '0);
    assign a_end     = en && (h_cnt == cfg_h_active - HCW'(1)) && (v_cnt == cfg_v_active - VCW'(1));
    assign cnt_match = en && (h_cnt == h_match) && (v_cnt == v_match);
    assign h_sync    = cfg_h_pol ^ (en && h_in_sync);
    assign v_sync    = cfg_v_pol ^ (en && v_in_sync);

endmodule

// File: tb/tb_video_sync_generator.sv
// Purpose: directed self-checking bench for video_sync_generator.
// Latency: inputs driven and outputs sampled on the falling edge, counters move on the rising edge.
// Backpressure: not applicable.
module tb_video_sync_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        en;
    logic [11:0] h_match;
    logic [11:0] v_match;
    logic        cfg_h_pol;
    logic [11:0] cfg_h_sync, cfg_h_active, cfg_h_front, cfg_h_whole;
    logic        cfg_v_pol;
    logic [11:0] cfg_v_sync, cfg_v_active, cfg_v_front, cfg_v_whole;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        cnt_match, active, blank, a_start, a_end;
    logic [5:0]  f_cnt;
    logic        h_sync, v_sync;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    video_sync_generator #(.HCW(12), .VCW(12), .F_CNT(60)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .en           (en),
        .h_match      (h_match),
        .v_match      (v_match),
        .cfg_h_pol    (cfg_h_pol),
        .cfg_h_sync   (cfg_h_sync),
        .cfg_h_active (cfg_h_active),
        .cfg_h_front  (cfg_h_front),
        .cfg_h_whole  (cfg_h_whole),
        .cfg_v_pol    (cfg_v_pol),
        .cfg_v_sync   (cfg_v_sync),
        .cfg_v_active (cfg_v_active),
        .cfg_v_front  (cfg_v_front),
        .cfg_v_whole  (cfg_v_whole),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .cnt_match    (cnt_match),
        .active       (active),
        .blank        (blank),
        .a_start      (a_start),
        .a_end        (a_end),
        .f_cnt        (f_cnt),
        .h_sync       (h_sync),
        .v_sync       (v_sync)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_pos(input string tag, input int h, input int v, input int f);
        chk({tag, ".h_cnt"}, 32'(h_cnt), 32'(h));
        chk({tag, ".v_cnt"}, 32'(v_cnt), 32'(v));
        chk({tag, ".f_cnt"}, 32'(f_cnt), 32'(f));
    endtask

    int n_match, n_start, n_end;

    initial begin
        // Small raster: line = 4 active, 1 front, 2 sync, 1 back (8 px);
        // frame = 3 active, 1 front, 1 sync, 1 back (6 lines) -> 48 clocks/frame.
        rst = 1'b1; clk_en = 1'b1; en = 1'b0;
        h_match = 12'd5; v_match = 12'd3;
        cfg_h_pol = 1'b0; cfg_h_active = 12'd4; cfg_h_front = 12'd1; cfg_h_sync = 12'd2; cfg_h_whole = 12'd8;
        cfg_v_pol = 1'b0; cfg_v_active = 12'd3; cfg_v_front = 12'd1; cfg_v_sync = 12'd1; cfg_v_whole = 12'd6;

        tick(2);
        chk_pos("reset", 0, 0, 0);
        chk("reset.active_en0", 32'(active), 0);
        chk("reset.blank_en0", 32'(blank), 1);
        chk("reset.a_start_en0", 32'(a_start), 0);
        chk("reset.h_sync_en0", 32'(h_sync), 0);
        chk("reset.v_sync_en0", 32'(v_sync), 0);
        en = 1'b1;
        #1;
        chk("reset.active_en1", 32'(active), 1);
        chk("reset.a_start_en1", 32'(a_start), 1);
        tick(1);
        rst = 1'b0;

        // One full frame, position derived from the elapsed clock count.
        n_match = 0; n_start = 0; n_end = 0;
        for (int k = 0; k < 48; k++) begin
            int h, v;
            h = k % 8;
            v = k / 8;
            chk("sweep.h_cnt", 32'(h_cnt), 32'(h));
            chk("sweep.v_cnt", 32'(v_cnt), 32'(v));
            chk("sweep.active", 32'(active), 32'(h < 4 && v < 3));
            chk("sweep.blank", 32'(blank), 32'(!(h < 4 && v < 3)));
            chk("sweep.h_sync", 32'(h_sync), 32'(h >= 5 && h <= 6));
            chk("sweep.v_sync", 32'(v_sync), 32'(v == 4));
            chk("sweep.a_start", 32'(a_start), 32'(k == 0));
            chk("sweep.a_end", 32'(a_end), 32'(h == 3 && v == 2));
            chk("sweep.cnt_match", 32'(cnt_match), 32'(h == 5 && v == 3));
            n_match += int'(cnt_match);
            n_start += int'(a_start);
            n_end   += int'(a_end);
            tick(1);
        end
        chk("sweep.match_once", 32'(n_match), 1);
        chk("sweep.start_once", 32'(n_start), 1);
        chk("sweep.end_once", 32'(n_end), 1);
        chk_pos("frame1", 0, 0, 1);

        // Inverted polarities.
        cfg_h_pol = 1'b1; cfg_v_pol = 1'b1;
        #1;
        chk("pol.h_idle", 32'(h_sync), 1);
        chk("pol.v_idle", 32'(v_sync), 1);
        tick(5);
        chk("pol.h_in_sync", 32'(h_sync), 0);
        chk("pol.v_idle2", 32'(v_sync), 1);
        tick(27);
        chk_pos("pol.pos", 0, 4, 1);
        chk("pol.v_in_sync", 32'(v_sync), 0);
        chk("pol.h_idle2", 32'(h_sync), 1);
        cfg_h_pol = 1'b0; cfg_v_pol = 1'b0;
        tick(16);
        chk_pos("frame2", 0, 0, 2);

        // clk_en every other cycle: counters hold on disabled cycles.
        for (int i = 0; i < 8; i++) begin
            clk_en = 1'b0;
            tick(1);
            chk("clken.hold", 32'(h_cnt), 32'(i));
            clk_en = 1'b1;
            tick(1);
        end
        chk_pos("clken.after", 0, 1, 2);

        // Run to the frame-59 last pixel, then wrap everything together.
        tick(40);
        chk_pos("frame3", 0, 0, 3);
        tick(56 * 48);
        chk_pos("frame59", 0, 0, 59);
        tick(47);
        chk_pos("last_px", 7, 5, 59);
        tick(1);
        chk_pos("wrap", 0, 0, 0);

        // Drop en in active area and in both sync windows.
        tick(19);
        chk_pos("en.pos1", 3, 2, 0);
        chk("en.active_before", 32'(active), 1);
        cfg_h_pol = 1'b1;
        en = 1'b0;
        #1;
        chk("en.active_off", 32'(active), 0);
        chk("en.h_sync_off", 32'(h_sync), 1);
        chk("en.v_sync_off", 32'(v_sync), 0);
        chk("en.a_end_off", 32'(a_end), 0);
        tick(1);
        chk_pos("en.cleared", 0, 0, 0);
        en = 1'b1;
        tick(1);
        chk_pos("en.restart", 1, 0, 0);
        cfg_v_pol = 1'b1;
        tick(36);
        chk_pos("en.pos2", 5, 4, 0);
        chk("en.h_sync_on", 32'(h_sync), 0);
        chk("en.v_sync_on", 32'(v_sync), 0);
        en = 1'b0;
        #1;
        chk("en.h_sync_rest", 32'(h_sync), 1);
        chk("en.v_sync_rest", 32'(v_sync), 1);
        tick(1);
        chk_pos("en.cleared2", 0, 0, 0);
        cfg_h_pol = 1'b0; cfg_v_pol = 1'b0;
        en = 1'b1;

        // Asynchronous reset mid-line: counters clear without a clock edge.
        tick(58);
        chk_pos("arst.before", 2, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_pos("arst.now", 0, 0, 0);
        tick(1);
        rst = 1'b0;

        // One line of the 800x600 timing: sync spans 840..967, active 0..799.
        cfg_h_active = 12'd800; cfg_h_front = 12'd40; cfg_h_sync = 12'd128; cfg_h_whole = 12'd1056;
        cfg_v_active = 12'd600; cfg_v_front = 12'd1;  cfg_v_sync = 12'd4;   cfg_v_whole = 12'd628;
        for (int k = 0; k < 1056; k++) begin
            chk("svga.h_cnt", 32'(h_cnt), 32'(k));
            chk("svga.h_sync", 32'(h_sync), 32'(k >= 840 && k <= 967));
            chk("svga.active", 32'(active), 32'(k < 800));
            tick(1);
        end
        chk_pos("svga.line1", 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
